// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage.
// IFETCH_DELAY_SLOT_EN adds the delay-slot state to the FSM enum.
package ifetch_pkg;

    typedef logic [29:0] addr_t;

    localparam logic [31:0] NOP_INST = 32'h00000000;

`ifdef IFETCH_DELAY_SLOT_EN
    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_SLOT
    } state_e;
`else
    typedef enum logic {
        S_BOOT,
        S_RUN
    } state_e;
`endif

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: drives a one-cycle-latency instruction memory.
// Define IFETCH_DELAY_SLOT_EN for a one-instruction branch delay slot.
module inst_fetch
    import ifetch_pkg::*;
#(
    parameter addr_t RESET_PC = 30'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_addr,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] inst,
    output logic [29:0] inst_pc,
    output logic        inst_valid
);

    state_e state_q, state_d;
    addr_t  pc_q, pc_d;
    addr_t  pc_inc;

`ifdef IFETCH_DELAY_SLOT_EN
    addr_t  tgt_q, tgt_d;
`endif

    assign pc_inc  = pc_q + 30'd1;
    assign inst    = imem_inst;
    assign inst_pc = pc_q;

    // State, pc and pending-target registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
`ifdef IFETCH_DELAY_SLOT_EN
            tgt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef IFETCH_DELAY_SLOT_EN
            tgt_q   <= tgt_d;
`endif
        end
    end

    // Next-state, next-address mux and valid generation
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        imem_addr  = pc_q;
        inst_valid = 1'b0;
`ifdef IFETCH_DELAY_SLOT_EN
        tgt_d      = tgt_q;
`endif
        case (state_q)
            S_BOOT: begin
                imem_addr = RESET_PC;
                pc_d      = RESET_PC;
                state_d   = S_RUN;
            end
            S_RUN: begin
                inst_valid = 1'b1;
                if (redirect_valid) begin
`ifdef IFETCH_DELAY_SLOT_EN
                    imem_addr = pc_inc;
                    pc_d      = pc_inc;
                    tgt_d     = redirect_addr;
                    state_d   = S_SLOT;
`else
                    imem_addr = redirect_addr;
                    pc_d      = redirect_addr;
`endif
                end else if (stall) begin
                    imem_addr = pc_q;
                end else begin
                    imem_addr = pc_inc;
                    pc_d      = pc_inc;
                end
            end
`ifdef IFETCH_DELAY_SLOT_EN
            S_SLOT: begin
                inst_valid = 1'b1;
                if (!stall) begin
                    imem_addr = tgt_q;
                    pc_d      = tgt_q;
                    state_d   = S_RUN;
                end
            end
`endif
            default: begin
                state_d = S_BOOT;
            end
        endcase
        // Reset overrides the outputs in the same cycle
        if (rst) begin
            imem_addr  = RESET_PC;
            inst_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch with a one-cycle memory model.
// Expectations follow IFETCH_DELAY_SLOT_EN when it is defined.
module tb_inst_fetch;
    import ifetch_pkg::*;

    typedef struct {
        logic  v;
        addr_t pc;
        addr_t a;
    } exp_t;

    localparam addr_t TOP = 30'h3FFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [29:0] redirect_addr = '0;
    logic [29:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic        inst_valid;
    logic [29:0] mem_a;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    inst_fetch #(.RESET_PC(30'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .imem_addr     (imem_addr),
        .imem_inst     (imem_inst),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid)
    );

    always #5 clk = ~clk;

    // Memory: word k holds 32'h1000_0000 + k, one-cycle latency
    always @(posedge clk) mem_a <= imem_addr;
    assign imem_inst = 32'h10000000 + {2'b00, mem_a};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic s,
                       input logic rv, input addr_t ra,
                       input logic ev, input addr_t epc,
                       input addr_t ea);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_addr  = ra;
        e.v  = ev;
        e.pc = epc;
        e.a  = ea;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("valid", {31'b0, inst_valid}, {31'b0, e.v});
            chk("addr", {2'b0, imem_addr}, {2'b0, e.a});
            chk("pass", inst, imem_inst);
            if (e.v) begin
                chk("pc", {2'b0, inst_pc}, {2'b0, e.pc});
                chk("inst", inst, 32'h10000000 + {2'b0, e.pc});
            end
        end
    end

    initial begin
        cyc(1, 0, 0, '0, 0, '0, '0);
        cyc(1, 0, 0, '0, 0, '0, '0);
        cyc(0, 0, 0, '0, 0, '0, '0);
        for (int k = 0; k < 5; k++)
            cyc(0, 0, 0, '0, 1, addr_t'(k), addr_t'(k + 1));
        for (int k = 0; k < 3; k++)
            cyc(0, 1, 0, '0, 1, 30'd5, 30'd5);
        cyc(0, 0, 0, '0, 1, 30'd5, 30'd6);
        cyc(0, 0, 0, '0, 1, 30'd6, 30'd7);
        cyc(0, 0, 0, '0, 1, 30'd7, 30'd8);
`ifdef IFETCH_DELAY_SLOT_EN
        cyc(0, 0, 1, 30'h40, 1, 30'd8, 30'd9);
        cyc(0, 0, 0, '0, 1, 30'd9, 30'h40);
        cyc(0, 0, 0, '0, 1, 30'h40, 30'h41);
        cyc(0, 0, 1, 30'h60, 1, 30'h41, 30'h42);
        cyc(0, 1, 1, 30'h80, 1, 30'h42, 30'h42);
        cyc(0, 1, 1, 30'h80, 1, 30'h42, 30'h42);
        cyc(0, 0, 1, 30'h80, 1, 30'h42, 30'h60);
        cyc(0, 0, 0, '0, 1, 30'h60, 30'h61);
        cyc(0, 0, 1, TOP, 1, 30'h61, 30'h62);
        cyc(0, 0, 0, '0, 1, 30'h62, TOP);
        cyc(0, 0, 0, '0, 1, TOP, 30'h0);
        cyc(0, 0, 0, '0, 1, 30'h0, 30'h1);
        cyc(0, 0, 1, 30'h40, 1, 30'h1, 30'h2);
        cyc(1, 0, 0, '0, 0, '0, 30'h0);
`else
        cyc(0, 0, 1, 30'h40, 1, 30'd8, 30'h40);
        cyc(0, 0, 0, '0, 1, 30'h40, 30'h41);
        cyc(0, 1, 1, 30'h60, 1, 30'h41, 30'h60);
        cyc(0, 0, 0, '0, 1, 30'h60, 30'h61);
        cyc(0, 0, 1, TOP, 1, 30'h61, TOP);
        cyc(0, 0, 0, '0, 1, TOP, 30'h0);
        cyc(0, 0, 0, '0, 1, 30'h0, 30'h1);
        cyc(0, 0, 1, 30'h40, 1, 30'h1, 30'h40);
        cyc(1, 0, 0, '0, 0, '0, 30'h0);
`endif
        cyc(0, 0, 0, '0, 0, '0, 30'h0);
        cyc(0, 0, 0, '0, 1, 30'h0, 30'h1);
        cyc(0, 0, 0, '0, 1, 30'h1, 30'h2);
        cyc(0, 0, 0, '0, 1, 30'h2, 30'h3);
        @(posedge clk);
        @(posedge clk);
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
